pipe_rx_fifo: RTL and testbench
===============================

# pipe_rx_fifo

Receive-side buffer for the three-stage 8-bit data pipeline: captures each valid word leaving the pipeline's final stage into a small show-ahead FIFO and presents it to a downstream consumer with a valid/ready handshake. The pipeline has no stall input, so this block absorbs rate mismatch, drops words when full, and reports the loss through sticky status and a drop counter. It sits directly after the pipeline's final stage.

## Interface
- DATA_W, 8, word width; matches the pipeline data width
- DEPTH, 4, FIFO entries; power of two, at least 2
- CNT_W, 8, drop-counter width
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  pipeline final-stage word is valid this cycle
- in_data  input  DATA_W  pipeline final-stage word
- out_valid  output  1  FIFO non-empty; out_data is valid
- out_data  output  DATA_W  head-of-FIFO word (show-ahead)
- out_ready  input  1  consumer accepts head word when out_valid=1
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  output  1  level == DEPTH
- overflow  output  1  sticky; set when a word was dropped
- drop_cnt  output  CNT_W  number of dropped words, saturating
- clr_status  input  1  synchronous clear of overflow and drop_cnt

## Operation
- push = in_valid & (~full | pop); pop = out_valid & out_ready.
- drop = in_valid & full & ~pop. A dropped word is discarded and never written.
- Storage: DEPTH-entry array with write and read pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. level is tracked explicitly: +1 on push only, -1 on pop only, unchanged on both or neither.
- out_data = mem[rd_ptr], valid whenever level>0. With level==0, out_data is don't-care and is not checked.
- No empty bypass: a word pushed while the FIFO is empty does not appear on out_data until the next cycle.
- Full with simultaneous pop and in_valid: pop and push both occur, the word is accepted, level stays DEPTH, and there is no drop.
- Empty with out_ready=1: no pop; pointers and level are unchanged.
- overflow is set on any drop cycle. drop_cnt increments on each drop and holds at 2^CNT_W-1.
- clr_status clears overflow and drop_cnt to 0. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_cnt=1.
- Reset mid-operation discards all contents immediately (asynchronous).

## Timing
- Reset values: out_valid=0, level=0, full=0, overflow=0, drop_cnt=0, and both pointers 0. out_data is don't-care.
- Latency is 1 cycle. A word pushed at rising edge N is on out_data with out_valid=1 after edge N, and can pop at edge N+1.
- Back-to-back streaming with out_ready held at 1 sustains 1 word per cycle with level steady at 1.
- All status outputs (level, full, overflow, drop_cnt) are registered or derived directly from registers, with no combinational path from inputs.
- out_valid and out_data depend only on registers. Only the internal pop logic uses out_ready.

## Structure
- Shared package pipe_pkg holds the DATA_W default, the DEPTH default, and a localparam function for the pointer width. The pipeline and this block both import it.
- Keep the block flat; no sub-module is needed. The storage array is written only on push and is not reset.

## Test plan
- Reset/idle: hold rst=0, then release with in_valid=0 for 5 cycles. Expect out_valid=0, level=0, overflow=0, drop_cnt=0.
- Single word: push 8'hAA with out_ready=0. One cycle later expect out_valid=1, out_data=AA, level=1. Then raise out_ready for one cycle; expect level=0 and out_valid=0.
- Fill/overflow: with out_ready=0, push AA, CC, 55, 33, then F0, 0F. Expect full=1, level=4, overflow=1, drop_cnt=2. Draining yields AA, CC, 55, 33 in order.
- Full with simultaneous push and pop: with the FIFO full (AA..33) and out_ready=1, push 77. Expect no drop and level stays 4. The drain order is CC, 55, 33, 77.
- Wrap-around: stream 0x00..0x13 with out_ready=1 at random 50% duty. Expect the output sequence to equal the input sequence minus reported drops, and drop_cnt to equal the scoreboard drop count.
- clr_status/reset: assert clr_status in the same cycle as a drop; expect overflow=1, drop_cnt=1. Then assert rst mid-stream; expect level=0 and out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared defaults for the 8-bit three-stage data pipeline and its receive buffer.
package pipe_pkg;

    localparam int PIPE_DATA_W = 8;
    localparam int PIPE_DEPTH  = 4;

    // Pointer width for a power-of-two FIFO depth (depth >= 2).
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pipe_rx_fifo.sv
// Receive-side show-ahead FIFO after the pipeline's final stage. The pipeline cannot stall,
// so words arriving while full are dropped and reported via sticky overflow and drop_cnt.
module pipe_rx_fifo
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int DEPTH  = PIPE_DEPTH,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    overflow,
    output logic [CNT_W-1:0]        drop_cnt,
    input  logic                    clr_status
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic push, pop, drop, is_full, not_empty;

    always_comb begin
        not_empty = (level_q != '0);
        is_full   = (level_q == LVL_W'(DEPTH));
        pop       = not_empty & out_ready;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push      = in_valid & (~is_full | pop);
        drop      = in_valid & is_full & ~pop;

        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a status clear takes precedence.
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = clr_status ? CNT_W'(1) : sat_inc(drop_cnt_q);
        end else if (clr_status) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid = not_empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pipe_rx_fifo.sv
// Bench for pipe_rx_fifo: directed scenarios plus randomized streaming against a queue model.
module tb_pipe_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [2:0]        level;
    logic              full;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;
    logic              clr_status;

    pipe_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .full(full), .overflow(overflow), .drop_cnt(drop_cnt),
        .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents as a queue, plus status counters.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_acc[$];
    logic [DATA_W-1:0] dut_popped[$];
    logic              m_ovf;
    int                m_cnt;
    int                m_ndrop;

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] d,
                               input logic r, input logic c);
        bit m_pop, m_full, m_push, m_drop;
        in_valid   = v;
        in_data    = d;
        out_ready  = r;
        clr_status = c;
        m_pop  = (mq.size() > 0) && r;
        m_full = (mq.size() == DEPTH);
        m_push = v && (!m_full || m_pop);
        m_drop = v && m_full && !m_pop;
        if (out_valid && r) dut_popped.push_back(out_data);
        @(posedge clk);
        #1;
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
            mq.push_back(d);
            m_acc.push_back(d);
        end
        if (m_drop) begin
            m_ndrop++;
            m_ovf = 1'b1;
            m_cnt = c ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt);
        end else if (c) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        clr_status = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_status = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_in_valid: got %b want 0", out_valid); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_in_level: got %0d want 0", level); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", out_valid); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL idle_level: got %0d want 0", level); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL idle_full: got %b want 0", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL idle_overflow: got %b want 0", overflow); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL idle_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_single();
        // Before the edge the empty FIFO must not bypass the incoming word.
        in_valid = 1'b1; in_data = 8'hAA; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass: got %b want 0", out_valid); end
        drive_cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 8'hAA) begin n_err++; $display("FAIL single_data: got %h want aa", out_data); end
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", level); end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL single_pop_level: got %0d want 0", level); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL empty_ready_level: got %0d want 0", level); end
    endtask

    task automatic test_fill_overflow();
        logic [DATA_W-1:0] words [6] = '{8'hAA, 8'hCC, 8'h55, 8'h33, 8'hF0, 8'h0F};
        logic [DATA_W-1:0] exp   [4] = '{8'hAA, 8'hCC, 8'h55, 8'h33};
        foreach (words[i]) drive_cycle(1'b1, words[i], 1'b0, 1'b0);
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fill_level: got %0d want 4", level); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow: got %b want 1", overflow); end
        n_cmp++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL fill_drop_cnt: got %0d want 2", drop_cnt); end
        foreach (exp[i]) begin
            n_cmp++; if (out_data !== exp[i]) begin n_err++; $display("FAIL drain_%0d: got %h want %h", i, out_data, exp[i]); end
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [DATA_W-1:0] words [4] = '{8'hAA, 8'hCC, 8'h55, 8'h33};
        logic [DATA_W-1:0] exp   [4] = '{8'hCC, 8'h55, 8'h33, 8'h77};
        foreach (words[i]) drive_cycle(1'b1, words[i], 1'b0, 1'b0);
        n_cmp++; if (out_data !== 8'hAA) begin n_err++; $display("FAIL fpp_head: got %h want aa", out_data); end
        drive_cycle(1'b1, 8'h77, 1'b1, 1'b0);
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fpp_level: got %0d want 4", level); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fpp_full: got %b want 1", full); end
        n_cmp++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL fpp_no_drop: got %0d want 2", drop_cnt); end
        foreach (exp[i]) begin
            n_cmp++; if (out_data !== exp[i]) begin n_err++; $display("FAIL fpp_drain_%0d: got %h want %h", i, out_data, exp[i]); end
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
            n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL b2b_level_%0d: got %0d want 1", i, level); end
            n_cmp++; if (out_data !== 8'(8'h40 + i)) begin n_err++; $display("FAIL b2b_data_%0d: got %h want %h", i, out_data, 8'(8'h40 + i)); end
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL b2b_end_level: got %0d want 0", level); end
    endtask

    task automatic test_wrap();
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_overflow: got %b want 0", overflow); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL clr_drop_cnt: got %0d want 0", drop_cnt); end
        m_acc.delete(); dut_popped.delete(); m_ndrop = 0;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 8'(i), 1'($urandom % 2), 1'b0);
            n_cmp++; if (level !== 3'(mq.size())) begin n_err++; $display("FAIL wrap_level_%0d: got %0d want %0d", i, level, mq.size()); end
        end
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (dut_popped.size() != m_acc.size()) begin n_err++; $display("FAIL wrap_count: got %0d want %0d", dut_popped.size(), m_acc.size()); end
        for (int i = 0; i < m_acc.size() && i < dut_popped.size(); i++) begin
            n_cmp++; if (dut_popped[i] !== m_acc[i]) begin n_err++; $display("FAIL wrap_word_%0d: got %h want %h", i, dut_popped[i], m_acc[i]); end
        end
        n_cmp++; if (drop_cnt !== 8'(m_ndrop)) begin n_err++; $display("FAIL wrap_drop_cnt: got %0d want %0d", drop_cnt, m_ndrop); end
        n_cmp++; if (m_acc.size() + m_ndrop != 20) begin n_err++; $display("FAIL wrap_accounting: got %0d want 20", m_acc.size() + m_ndrop); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < CNT_MAX + 3; i++) drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        n_cmp++; if (drop_cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL sat_model: got %0d want %0d", drop_cnt, m_cnt); end
        n_cmp++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL sat_drop_cnt: got %0d want 255", drop_cnt); end
        n_cmp++; if (out_data !== 8'hA0) begin n_err++; $display("FAIL sat_head_kept: got %h want a0", out_data); end
    endtask

    task automatic test_clr_status();
        drive_cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL clr_drop_ovf: got %b want 1", overflow); end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL clr_drop_cnt: got %0d want 1", drop_cnt); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_only_ovf: got %b want 0", overflow); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL clr_only_cnt: got %0d want 0", drop_cnt); end
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL clr_keeps_level: got %0d want 4", level); end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h11, 1'b1, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL async_level: got %0d want 0", level); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", out_valid); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL async_full: got %b want 0", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL async_overflow: got %b want 0", overflow); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL async_drop_cnt: got %0d want 0", drop_cnt); end
        @(posedge clk);
        #1 rst = 1'b1;
        drive_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        n_cmp++; if (out_data !== 8'h5A || level !== 3'd1) begin n_err++; $display("FAIL post_reset_push: got %h/%0d want 5a/1", out_data, level); end
    endtask

    initial begin
        m_ndrop = 0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_wrap();
        test_saturate();
        test_clr_status();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
